msrv32_instr_fetch_unit: RTL and testbench

Front-end stage directly upstream of the instruction decoder. Owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake, tolerating wait states. Buffers returned words in a small in-order prefetch queue and presents one instruction per cycle with its PC. Drives flush_out so the decoder substitutes NOP (32'h00000013) whenever no valid instruction is present or a redirect occurs.

---
 rtl/msrv32_pkg.sv | 9 +
 rtl/msrv32_fetch_fifo.sv | 110 +++++++++++
 rtl/msrv32_instr_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_msrv32_instr_fetch_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 front end.
package msrv32_pkg;

    localparam int          DEFAULT_WIDTH        = 32;
    localparam logic [31:0] DEFAULT_BOOT_ADDRESS = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] PC_INCR              = 32'h0000_0004;

endpackage

// File: rtl/msrv32_fetch_fifo.sv
// In-order prefetch queue of {instr, pc} with a registered head entry.
module msrv32_fetch_fifo
    import msrv32_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_instr,
    input  logic [WIDTH-1:0]       i_push_pc,
    input  logic                   i_pop,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_head_valid,
    output logic [WIDTH-1:0]       o_head_instr,
    output logic [WIDTH-1:0]       o_head_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_instr_mem [DEPTH];
    logic [WIDTH-1:0] r_pc_mem    [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_head_valid;
    logic [WIDTH-1:0] r_head_instr;
    logic [WIDTH-1:0] r_head_pc;

    logic             w_pop;
    logic             w_push;
    logic [CW-1:0]    w_count_after_pop;
    logic [CW-1:0]    w_count_next;
    logic [PW-1:0]    w_rd_ptr_next;
    logic [PW-1:0]    w_wr_ptr_next;
    logic             w_head_valid_next;
    logic [WIDTH-1:0] w_head_instr_next;
    logic [WIDTH-1:0] w_head_pc_next;

    // Next pointers/count and the entry that becomes the head after this edge
    always_comb begin
        w_pop             = i_pop && r_head_valid;
        w_count_after_pop = r_count - CW'(w_pop);
        w_push            = i_push && (w_count_after_pop < CW'(DEPTH));
        w_rd_ptr_next     = r_rd_ptr;
        w_wr_ptr_next     = r_wr_ptr;
        w_count_next      = r_count;
        w_head_valid_next = 1'b0;
        w_head_instr_next = WIDTH'(NOP_INSTR);
        w_head_pc_next    = r_head_pc;
        if (i_clear) begin
            w_rd_ptr_next = {PW{1'b0}};
            w_wr_ptr_next = {PW{1'b0}};
            w_count_next  = {CW{1'b0}};
        end else begin
            w_rd_ptr_next = r_rd_ptr + PW'(w_pop);
            w_wr_ptr_next = r_wr_ptr + PW'(w_push);
            w_count_next  = w_count_after_pop + CW'(w_push);
            if (w_count_next == {CW{1'b0}}) begin
                w_head_valid_next = 1'b0;
            end else if (w_count_after_pop == {CW{1'b0}}) begin
                // queue drains this cycle, so the incoming word goes straight to the head
                w_head_valid_next = 1'b1;
                w_head_instr_next = i_push_instr;
                w_head_pc_next    = i_push_pc;
            end else begin
                w_head_valid_next = 1'b1;
                w_head_instr_next = r_instr_mem[w_rd_ptr_next];
                w_head_pc_next    = r_pc_mem[w_rd_ptr_next];
            end
        end
    end

    // Queue control state and registered head
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr     <= {PW{1'b0}};
            r_wr_ptr     <= {PW{1'b0}};
            r_count      <= {CW{1'b0}};
            r_head_valid <= 1'b0;
            r_head_instr <= WIDTH'(NOP_INSTR);
            r_head_pc    <= RESET_PC;
        end else begin
            r_rd_ptr     <= w_rd_ptr_next;
            r_wr_ptr     <= w_wr_ptr_next;
            r_count      <= w_count_next;
            r_head_valid <= w_head_valid_next;
            r_head_instr <= w_head_instr_next;
            r_head_pc    <= w_head_pc_next;
        end
    end

    // Entry storage; contents are only read while counted as valid
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_clear && w_push) begin
            r_instr_mem[r_wr_ptr] <= i_push_instr;
            r_pc_mem[r_wr_ptr]    <= i_push_pc;
        end
    end

    assign o_count      = r_count;
    assign o_head_valid = r_head_valid;
    assign o_head_instr = r_head_instr;
    assign o_head_pc    = r_head_pc;

endmodule

// File: rtl/msrv32_instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited imem requests and presents one instruction per cycle.
module msrv32_instr_fetch_unit
    import msrv32_pkg::*;
#(
    parameter int               WIDTH        = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] BOOT_ADDRESS = WIDTH'(DEFAULT_BOOT_ADDRESS),
    parameter int               FIFO_DEPTH   = 2
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic             redirect_in,
    input  logic [WIDTH-1:0] redirect_pc_in,
    input  logic             stall_in,
    output logic             imem_req_out,
    output logic [WIDTH-1:0] imem_addr_out,
    input  logic             imem_gnt_in,
    input  logic             imem_rvalid_in,
    input  logic [WIDTH-1:0] imem_rdata_in,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] instr_pc_out,
    output logic             instr_valid_out,
    output logic             flush_out
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int QW = PW + 1;
    // one spare bit so stacked redirects cannot wrap the in-flight counters
    localparam int CW = PW + 2;
    localparam int SW = CW + 2;

    logic             r_req;
    logic [WIDTH-1:0] r_fetch_pc;
    logic [CW-1:0]    r_outstanding;
    logic [CW-1:0]    r_drop;
    logic [WIDTH-1:0] r_shadow_pc [FIFO_DEPTH];
    logic [PW-1:0]    r_sh_rd;
    logic [PW-1:0]    r_sh_wr;

    logic             w_hs;
    logic             w_rv_live;
    logic             w_rv_drop;
    logic             w_push;
    logic             w_pop;
    logic [QW-1:0]    w_q_count;
    logic             w_head_valid;
    logic [WIDTH-1:0] w_head_instr;
    logic [WIDTH-1:0] w_head_pc;
    logic [CW-1:0]    w_out_next;
    logic [CW-1:0]    w_drop_next;
    logic [CW-1:0]    w_count_next;
    logic [SW-1:0]    w_inflight_next;
    logic [WIDTH-1:0] w_fetch_pc_next;
    logic             w_req_next;

    // Handshake decode, credit accounting and next fetch request
    always_comb begin
        w_hs            = r_req && imem_gnt_in;
        w_rv_live       = imem_rvalid_in && ((r_drop != {CW{1'b0}}) || (r_outstanding != {CW{1'b0}}));
        w_rv_drop       = imem_rvalid_in && (r_drop != {CW{1'b0}});
        w_push          = imem_rvalid_in && (r_drop == {CW{1'b0}}) &&
                          (r_outstanding != {CW{1'b0}}) && !redirect_in;
        w_pop           = w_head_valid && !stall_in && !redirect_in;
        w_out_next      = r_outstanding;
        w_drop_next     = r_drop;
        w_count_next    = CW'(w_q_count);
        w_fetch_pc_next = r_fetch_pc;
        w_req_next      = r_req;
        w_inflight_next = {SW{1'b0}};
        if (redirect_in) begin
            // everything still in flight, including a grant this cycle, is now stale
            w_drop_next     = r_drop + r_outstanding + CW'(w_hs) - CW'(w_rv_live);
            w_out_next      = {CW{1'b0}};
            w_count_next    = {CW{1'b0}};
            w_fetch_pc_next = redirect_pc_in & ~WIDTH'(3);
            w_req_next      = 1'b1;
        end else begin
            w_drop_next     = r_drop - CW'(w_rv_drop);
            w_out_next      = r_outstanding + CW'(w_hs) - CW'(w_push);
            w_count_next    = CW'(w_q_count) + CW'(w_push) - CW'(w_pop);
            w_inflight_next = SW'(w_count_next) + SW'(w_out_next) + SW'(w_drop_next);
            if (w_hs) begin
                w_fetch_pc_next = r_fetch_pc + WIDTH'(PC_INCR);
            end else begin
                w_fetch_pc_next = r_fetch_pc;
            end
            if (r_req && !imem_gnt_in) begin
                w_req_next = 1'b1;
            end else begin
                w_req_next = (w_inflight_next < SW'(FIFO_DEPTH));
            end
        end
    end

    // Request, fetch PC and in-flight counters
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_req         <= 1'b0;
            r_fetch_pc    <= BOOT_ADDRESS;
            r_outstanding <= {CW{1'b0}};
            r_drop        <= {CW{1'b0}};
        end else begin
            r_req         <= w_req_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_outstanding <= w_out_next;
            r_drop        <= w_drop_next;
        end
    end

    // PC shadow pointers: one slot per live outstanding request, in grant order
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in || redirect_in) begin
            r_sh_rd <= {PW{1'b0}};
            r_sh_wr <= {PW{1'b0}};
        end else begin
            r_sh_wr <= r_sh_wr + PW'(w_hs);
            r_sh_rd <= r_sh_rd + PW'(w_push);
        end
    end

    // PC shadow storage captured at grant time
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in && !redirect_in && w_hs) begin
            r_shadow_pc[r_sh_wr] <= r_fetch_pc;
        end
    end

    msrv32_fetch_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (FIFO_DEPTH),
        .RESET_PC (BOOT_ADDRESS)
    ) u_fetch_fifo (
        .i_clk        (ms_riscv32_mp_clk_in),
        .i_rst        (ms_riscv32_mp_rst_in),
        .i_clear      (redirect_in),
        .i_push       (w_push),
        .i_push_instr (imem_rdata_in),
        .i_push_pc    (r_shadow_pc[r_sh_rd]),
        .i_pop        (w_pop),
        .o_count      (w_q_count),
        .o_head_valid (w_head_valid),
        .o_head_instr (w_head_instr),
        .o_head_pc    (w_head_pc)
    );

    assign imem_req_out    = r_req;
    assign imem_addr_out   = r_fetch_pc;
    assign instr_out       = w_head_instr;
    assign instr_pc_out    = w_head_pc;
    assign instr_valid_out = w_head_valid;
    assign flush_out       = !w_head_valid || redirect_in;

endmodule

// File: tb/tb_msrv32_instr_fetch_unit.sv
// Directed cycle table for msrv32_instr_fetch_unit plus a randomised-wait memory run with a PC scoreboard.
module tb_msrv32_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        valid;
    logic        flush;

    int n_tests;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    msrv32_instr_fetch_unit #(
        .WIDTH        (32),
        .BOOT_ADDRESS (32'h0000_0000),
        .FIFO_DEPTH   (2)
    ) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .redirect_in          (redirect),
        .redirect_pc_in       (redirect_pc),
        .stall_in             (stall),
        .imem_req_out         (req),
        .imem_addr_out        (addr),
        .imem_gnt_in          (gnt),
        .imem_rvalid_in       (rvalid),
        .imem_rdata_in        (rdata),
        .instr_out            (instr),
        .instr_pc_out         (instr_pc),
        .instr_valid_out      (valid),
        .flush_out            (flush)
    );

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_flush;
        logic        chk_pc;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(input logic r, input logic g, input logic v, input logic [31:0] d,
                                input logic s, input logic rd, input logic [31:0] rp,
                                input logic eq, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep, input logic ef,
                                input logic cp);
        vec_t t;
        t.rst = r;  t.gnt = g;  t.rv = v;  t.rdata = d;  t.stall = s;  t.redir = rd;  t.rpc = rp;
        t.e_req = eq;  t.e_addr = ea;  t.e_valid = ev;  t.e_instr = ei;  t.e_pc = ep;
        t.e_flush = ef;  t.chk_pc = cp;
        return t;
    endfunction

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int          accepted;
    logic [31:0] exp_pc;
    logic        pend_v;
    logic [31:0] pend_a;
    int          wait_cnt;
    int          cur_delay;
    logic        prev_pending;
    logic [31:0] prev_addr;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;  redirect = 1'b0;  redirect_pc = 32'h0;  stall = 1'b0;
        gnt = 1'b0;  rvalid = 1'b0;  rdata = 32'h0;

        //             rst   gnt   rv    rdata          stall redir rpc             req   addr           valid instr          pc             flush chkpc
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_0000, 1'b0, NOP,           32'h0000_0000, 1'b1, 1'b1);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0000, 1'b0, NOP,           32'h0,         1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0004, 1'b0, NOP,           32'h0,         1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b1, 32'hA000_0001, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_0008, 1'b1, 32'hA000_0000, 32'h0000_0000, 1'b0, 1'b1);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,          1'b1, 32'h0000_0008, 1'b1, 32'hA000_0001, 32'h0000_0004, 1'b0, 1'b1);
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, 32'hA000_0002, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_000C, 1'b1, 32'hA000_0001, 32'h0000_0004, 1'b0, 1'b1);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,          1'b0, 32'h0000_000C, 1'b1, 32'hA000_0001, 32'h0000_0004, 1'b0, 1'b1);
        vecs[7]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_000C, 1'b1, 32'hA000_0001, 32'h0000_0004, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,          1'b1, 32'h0000_000C, 1'b1, 32'hA000_0002, 32'h0000_0008, 1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,          1'b1, 32'h0000_000C, 1'b1, 32'hA000_0002, 32'h0000_0008, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0103,  1'b0, 32'h0000_0010, 1'b1, 32'hA000_0002, 32'h0000_0008, 1'b1, 1'b1);
        vecs[11] = mk(1'b0, 1'b1, 1'b1, 32'hA000_0003, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0100, 1'b0, NOP,           32'h0,         1'b1, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b1, 32'hB000_0000, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0104, 1'b0, NOP,           32'h0,         1'b1, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0203,  1'b1, 32'h0000_0104, 1'b1, 32'hB000_0000, 32'h0000_0100, 1'b1, 1'b1);
        vecs[14] = mk(1'b0, 1'b0, 1'b1, 32'hB000_0001, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0200, 1'b0, NOP,           32'h0,         1'b1, 1'b0);
        vecs[15] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0200, 1'b0, NOP,           32'h0,         1'b1, 1'b0);
        vecs[16] = mk(1'b0, 1'b0, 1'b1, 32'hC000_0000, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0204, 1'b0, NOP,           32'h0,         1'b1, 1'b0);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0204, 1'b1, 32'hC000_0000, 32'h0000_0200, 1'b0, 1'b1);
        vecs[18] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0204, 1'b0, NOP,           32'h0,         1'b1, 1'b0);
        vecs[19] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0208, 1'b0, NOP,           32'h0,         1'b1, 1'b0);
        vecs[20] = mk(1'b0, 1'b0, 1'b1, 32'hD000_0000, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0000_0000, 1'b0, NOP,           32'h0000_0000, 1'b1, 1'b1);
        vecs[21] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0000, 1'b0, NOP,           32'h0,         1'b1, 1'b0);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0000, 1'b0, NOP,           32'h0,         1'b1, 1'b0);

        repeat (2) @(posedge clk);

        // Directed cycle table: inputs for cycle k, outputs observed in cycle k
        for (int k = 0; k < 23; k++) begin
            @(posedge clk);
            #1;
            rst = vecs[k].rst;  gnt = vecs[k].gnt;  rvalid = vecs[k].rv;  rdata = vecs[k].rdata;
            stall = vecs[k].stall;  redirect = vecs[k].redir;  redirect_pc = vecs[k].rpc;
            @(negedge clk);
            chk($sformatf("vec%0d.req", k),   32'(req),   32'(vecs[k].e_req));
            chk($sformatf("vec%0d.addr", k),  addr,       vecs[k].e_addr);
            chk($sformatf("vec%0d.valid", k), 32'(valid), 32'(vecs[k].e_valid));
            chk($sformatf("vec%0d.instr", k), instr,      vecs[k].e_instr);
            chk($sformatf("vec%0d.flush", k), 32'(flush), 32'(vecs[k].e_flush));
            if (vecs[k].chk_pc) begin
                chk($sformatf("vec%0d.pc", k), instr_pc, vecs[k].e_pc);
            end
        end

        // Memory model run: random grant waits, random stalls, scheduled redirects incl. back-to-back and wrap
        @(posedge clk);
        #1;
        rst = 1'b1;  gnt = 1'b0;  rvalid = 1'b0;  stall = 1'b0;  redirect = 1'b0;
        repeat (2) @(posedge clk);
        accepted = 0;  exp_pc = 32'h0;  pend_v = 1'b0;  pend_a = 32'h0;
        wait_cnt = 0;  cur_delay = 0;  prev_pending = 1'b0;  prev_addr = 32'h0;
        for (int cyc = 0; cyc < 160; cyc++) begin
            @(posedge clk);
            #1;
            rst    = 1'b0;
            rvalid = pend_v;
            rdata  = pend_v ? mem_data(pend_a) : 32'h0;
            pend_v = 1'b0;
            gnt    = req && (wait_cnt >= cur_delay);
            stall  = ($urandom_range(0, 3) == 0);
            redirect    = (cyc == 30) || (cyc == 60) || (cyc == 61) || (cyc == 90);
            redirect_pc = (cyc == 30) ? 32'h0000_1003 :
                          (cyc == 60) ? 32'h0000_2000 :
                          (cyc == 61) ? 32'h0000_3002 : 32'hFFFF_FFF9;
            @(negedge clk);
            chk($sformatf("run%0d.flush", cyc), 32'(flush), 32'(!valid || redirect));
            if (prev_pending) begin
                chk($sformatf("run%0d.req_held", cyc),  32'(req), 32'h1);
                chk($sformatf("run%0d.addr_held", cyc), addr,     prev_addr);
            end
            if (valid && !stall && !redirect) begin
                chk($sformatf("run%0d.pc", cyc),    instr_pc, exp_pc);
                chk($sformatf("run%0d.instr", cyc), instr,    mem_data(exp_pc));
                exp_pc = exp_pc + 32'h4;
                accepted++;
            end
            if (redirect) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end
            if (req && gnt) begin
                pend_v    = 1'b1;
                pend_a    = addr;
                wait_cnt  = 0;
                cur_delay = int'($urandom_range(0, 3));
            end else if (req) begin
                wait_cnt++;
            end
            prev_pending = req && !gnt && !redirect;
            prev_addr    = addr;
        end
        chk("run.enough_accepted", 32'(accepted >= 20), 32'h1);
        chk("run.pc_wrapped", 32'(exp_pc < 32'h0000_0100), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
